// File: rtl/oscan1_host_pkg.sv
// Shared types and constants for the host-side OScan1 transmitter.
package oscan1_host_pkg;

    typedef enum logic [2:0] {
        ST_OFFLINE,
        ST_ESC,
        ST_OAC,
        ST_IDLE,
        ST_SLOT0,
        ST_SLOT1,
        ST_SLOT2,
        ST_RSP
    } state_t;

    // Activation code, transmitted LSB first
    localparam logic [11:0] ACT_CODE        = 12'b0000_1000_1100;
    localparam logic [3:0]  ESC_SEL_TOGGLES = 4'd6;
    localparam logic [3:0]  ESC_RST_TOGGLES = 4'd8;
    localparam logic [3:0]  OAC_BITS        = 4'd12;

    // Link is online while idle or while a bit-cycle packet is in flight
    function automatic logic is_online(state_t s);
        return (s == ST_IDLE) || (s == ST_SLOT0) || (s == ST_SLOT1) ||
               (s == ST_SLOT2) || (s == ST_RSP);
    endfunction

    // Busy covers everything except the two resting states
    function automatic logic is_busy(state_t s);
        return (s != ST_OFFLINE) && (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/oscan1_host_if.sv
// Bit-cycle command / TDO response channel between probe logic and the OScan1 host.
interface oscan1_host_if;

    logic cmd_valid;
    logic cmd_ready;
    logic cmd_tms;
    logic cmd_tdi;
    logic rsp_valid;
    logic rsp_tdo;

    modport master (
        output cmd_valid, cmd_tms, cmd_tdi,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_tms, cmd_tdi,
        output cmd_ready, rsp_valid, rsp_tdo
    );

endinterface

// File: rtl/oscan1_phase_timer.sv
// Divides clk into TCKC half-periods: strobes the last clk of each half and
// tracks whether the current half is the low or the high one.
module oscan1_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_end,
    output logic high_phase
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_end = (cnt == LAST);

    // Count clks within a half; a restart always lands at the start of a low half
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt        <= '0;
            high_phase <= 1'b0;
        end else if (half_end) begin
            cnt        <= '0;
            high_phase <= ~high_phase;
        end else begin
            cnt        <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/oscan1_host.sv
// Host-side OScan1 transmitter: brings the cJTAG link online with an escape and
// activation code, then turns each TMS/TDI bit-cycle into a 3-slot packet and
// returns the TDO the target drives in the third slot.
module oscan1_host
    import oscan1_host_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic activate,
    input  logic deactivate,
    output logic active,
    output logic busy,
    oscan1_host_if.slave cmd_bus,
    output logic tckc,
    output logic tmsc_out,
    output logic tmsc_oen,
    input  logic tmsc_in
);

    state_t     state;
    logic [3:0] count;
    logic [3:0] esc_target;
    logic       tms_q;
    logic       half_end;
    logic       high_phase;
    logic       esc_done;
    logic       timer_restart;

    assign esc_done      = (state == ST_ESC) && half_end && (count == esc_target);
    assign timer_restart = (state == ST_OFFLINE) || (state == ST_IDLE) ||
                           (state == ST_RSP) || esc_done;

    oscan1_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (timer_restart),
        .half_end   (half_end),
        .high_phase (high_phase)
    );

    assign active            = is_online(state);
    assign busy              = is_busy(state);
    assign cmd_bus.cmd_ready = (state == ST_IDLE) && !deactivate;

    // Link sequencer: escapes, activation code, packet slots and response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_OFFLINE;
            count             <= '0;
            esc_target        <= ESC_SEL_TOGGLES;
            tms_q             <= 1'b0;
            tckc              <= 1'b0;
            tmsc_out          <= 1'b1;
            tmsc_oen          <= 1'b1;
            cmd_bus.rsp_valid <= 1'b0;
            cmd_bus.rsp_tdo   <= 1'b0;
        end else begin
            cmd_bus.rsp_valid <= 1'b0;
            case (state)
                ST_OFFLINE: begin
                    if (activate) begin
                        state      <= ST_ESC;
                        esc_target <= ESC_SEL_TOGGLES;
                        count      <= '0;
                        tckc       <= 1'b1;
                        tmsc_out   <= 1'b1;
                        tmsc_oen   <= 1'b1;
                    end
                end
                ST_ESC: begin
                    if (half_end) begin
                        if (count == esc_target) begin
                            tckc  <= 1'b0;
                            count <= '0;
                            if (esc_target == ESC_SEL_TOGGLES) begin
                                state    <= ST_OAC;
                                tmsc_out <= ACT_CODE[0];
                            end else begin
                                state    <= ST_OFFLINE;
                                tmsc_out <= 1'b1;
                            end
                        end else begin
                            count    <= count + 4'd1;
                            tmsc_out <= ~tmsc_out;
                        end
                    end
                end
                ST_OAC: begin
                    if (half_end) begin
                        if (!high_phase) begin
                            tckc <= 1'b1;
                        end else begin
                            tckc <= 1'b0;
                            if (count == OAC_BITS - 4'd1) begin
                                state <= ST_IDLE;
                            end else begin
                                count    <= count + 4'd1;
                                tmsc_out <= ACT_CODE[count + 4'd1];
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (deactivate) begin
                        state      <= ST_ESC;
                        esc_target <= ESC_RST_TOGGLES;
                        count      <= '0;
                        tckc       <= 1'b1;
                        tmsc_out   <= 1'b1;
                        tmsc_oen   <= 1'b1;
                    end else if (cmd_bus.cmd_valid) begin
                        state    <= ST_SLOT0;
                        tms_q    <= cmd_bus.cmd_tms;
                        tmsc_out <= ~cmd_bus.cmd_tdi;
                        tmsc_oen <= 1'b1;
                    end
                end
                ST_SLOT0: begin
                    if (half_end) begin
                        if (!high_phase) begin
                            tckc <= 1'b1;
                        end else begin
                            tckc     <= 1'b0;
                            state    <= ST_SLOT1;
                            tmsc_out <= tms_q;
                        end
                    end
                end
                ST_SLOT1: begin
                    if (half_end) begin
                        if (!high_phase) begin
                            tckc <= 1'b1;
                        end else begin
                            tckc     <= 1'b0;
                            state    <= ST_SLOT2;
                            tmsc_oen <= 1'b0;
                        end
                    end
                end
                ST_SLOT2: begin
                    if (half_end) begin
                        if (!high_phase) begin
                            tckc <= 1'b1;
                        end else begin
                            tckc              <= 1'b0;
                            state             <= ST_RSP;
                            tmsc_oen          <= 1'b1;
                            cmd_bus.rsp_valid <= 1'b1;
                            cmd_bus.rsp_tdo   <= tmsc_in;
                        end
                    end
                end
                ST_RSP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_OFFLINE;
                end
            endcase
        end
    end

endmodule
